serial_compare_ctrl: RTL and testbench



---
 rtl/serial_compare_ctrl.sv | 164 ++++++++++++++++
 tb/tb_serial_compare_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_compare_ctrl.sv
// Bit-serial unsigned magnitude comparator: one operand pair in, walked MSB-first
// through a single 1-bit compare cell, one gt/lt/eq result out.
module serial_compare_ctrl #(
   parameter int WIDTH      = 8,
   parameter int EARLY_EXIT = 1,
   parameter int CW         = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             gt,
   output logic             lt,
   output logic             eq,
   output logic [CW-1:0]    steps,
   output logic [1:0]       state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
   // in_ready is high only in IDLE, out_valid only in DONE; each side holds its
   // payload stable while valid is high and the other side is not ready.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic             p_q, p_d;
   logic             q_q, q_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             gt_q, gt_d;
   logic             lt_q, lt_d;
   logic             eq_q, eq_d;
   logic [CW-1:0]    steps_q, steps_d;

   logic a_bit, b_bit;
   logic p_nxt, q_nxt;
   logic scan_last;

   // The compare cell: once one side wins, the other flag can never set.
   assign a_bit = a_sh_q[WIDTH-1];
   assign b_bit = b_sh_q[WIDTH-1];
   assign p_nxt = p_q | (~q_q & a_bit & ~b_bit);
   assign q_nxt = q_q | (~p_q & ~a_bit & b_bit);
   assign scan_last = ((EARLY_EXIT != 0) && (p_nxt | q_nxt)) || (idx_q == '0);

   always_comb begin
      state_d     = state_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      p_d         = p_q;
      q_d         = q_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      gt_d        = gt_q;
      lt_d        = lt_q;
      eq_d        = eq_q;
      steps_d     = steps_q;

      case (state_q)
         S_IDLE: begin
            in_ready_d = 1'b1;
            if (in_valid && in_ready_q) begin
               a_sh_d     = A;
               b_sh_d     = B;
               p_d        = 1'b0;
               q_d        = 1'b0;
               idx_d      = CW'(WIDTH - 1);
               cnt_d      = '0;
               in_ready_d = 1'b0;
               state_d    = S_SCAN;
            end
         end
         S_SCAN: begin
            a_sh_d = a_sh_q << 1;
            b_sh_d = b_sh_q << 1;
            p_d    = p_nxt;
            q_d    = q_nxt;
            cnt_d  = cnt_q + CW'(1);
            if (scan_last) begin
               out_valid_d = 1'b1;
               gt_d        = p_nxt;
               lt_d        = q_nxt;
               eq_d        = ~(p_nxt | q_nxt);
               steps_d     = cnt_q + CW'(1);
               state_d     = S_DONE;
            end else begin
               idx_d = idx_q - CW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               gt_d        = 1'b0;
               lt_d        = 1'b0;
               eq_d        = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            gt_d        = 1'b0;
            lt_d        = 1'b0;
            eq_d        = 1'b0;
            in_ready_d  = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         p_q         <= 1'b0;
         q_q         <= 1'b0;
         idx_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         gt_q        <= 1'b0;
         lt_q        <= 1'b0;
         eq_q        <= 1'b0;
         steps_q     <= '0;
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         p_q         <= p_d;
         q_q         <= q_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         gt_q        <= gt_d;
         lt_q        <= lt_d;
         eq_q        <= eq_d;
         steps_q     <= steps_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign gt        = gt_q;
   assign lt        = lt_q;
   assign eq        = eq_q;
   assign steps     = steps_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl: three configurations (W8 early-exit, W8 full scan,
// W5 early-exit) share one reset; drivers push expectations, a monitor pops them.
module tb_serial_compare_ctrl;

   localparam int N = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [N-1:0] in_valid = '0;
   logic [N-1:0] in_ready, out_valid, out_ready, gt, lt, eq;
   logic [7:0]   a_in [N];
   logic [7:0]   b_in [N];
   logic [3:0]   st0, st1;
   logic [2:0]   st2;
   logic [1:0]   dbg0, dbg1, dbg2;

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // entry: {dut id[1:0], gt, lt, eq, steps[3:0], expected first-valid cycle[31:0]}
   logic [40:0]  exp_q[$];
   logic [40:0]  cur [N];
   logic [N-1:0] busy     = '0;
   logic [N-1:0] pend_rdy = '0;
   logic [N-1:0] rand_or  = '0;
   logic [N-1:0] dir_or   = '1;

   serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) u_dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .A(a_in[0]), .B(b_in[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .gt(gt[0]), .lt(lt[0]), .eq(eq[0]), .steps(st0), .state_dbg(dbg0));

   serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) u_dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .A(a_in[1]), .B(b_in[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .gt(gt[1]), .lt(lt[1]), .eq(eq[1]), .steps(st1), .state_dbg(dbg1));

   serial_compare_ctrl #(.WIDTH(5), .EARLY_EXIT(1)) u_dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .A(a_in[2][4:0]), .B(b_in[2][4:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .gt(gt[2]), .lt(lt[2]), .eq(eq[2]), .steps(st2), .state_dbg(dbg2));

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] steps_of(int id);
      if (id == 0) return st0;
      if (id == 1) return st1;
      return {1'b0, st2};
   endfunction

   function automatic logic [1:0] dbg_of(int id);
      if (id == 0) return dbg0;
      if (id == 1) return dbg1;
      return dbg2;
   endfunction

   // Reference: plain unsigned compare plus the documented latency rule.
   function automatic logic [6:0] model(int id, logic [7:0] a, logic [7:0] b);
      int         w;
      bit         early;
      int         k;
      bit         found;
      logic [7:0] ma, mb;
      logic [2:0] f;
      w     = (id == 2) ? 5 : 8;
      early = (id != 1);
      ma    = (id == 2) ? (a & 8'h1F) : a;
      mb    = (id == 2) ? (b & 8'h1F) : b;
      f     = (ma > mb) ? 3'b100 : ((ma < mb) ? 3'b010 : 3'b001);
      k     = w;
      found = 1'b0;
      if (early && ma != mb) begin
         for (int j = w - 1; j >= 0; j--) begin
            if (!found && ma[j] != mb[j]) begin
               k     = w - j;
               found = 1'b1;
            end
         end
      end
      return {f, 4'(k)};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_cleared(int id);
      check("rst_in_ready", in_ready[id], 0);
      check("rst_out_valid", out_valid[id], 0);
      check("rst_flags", {gt[id], lt[id], eq[id]}, 0);
      check("rst_steps", steps_of(id), 0);
      check("rst_state", dbg_of(id), 0);
   endtask

   task automatic send(int id, logic [7:0] a, logic [7:0] b, logic [2:0] ef, logic [3:0] es,
                       int gap, bit push);
      bit         ok;
      logic [1:0] idb;
      idb = 2'(id);
      ok  = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
      a_in[id]     = a;
      b_in[id]     = b;
      in_valid[id] = 1'b1;
      for (int t = 0; t < 300 && !ok; t++) begin
         @(posedge clk);
         if (in_ready[id]) ok = 1'b1;
      end
      if (ok) begin
         if (push) exp_q.push_back({idb, ef, es, 32'(cyc + int'(es) + 1)});
      end else begin
         n_vec++;
         n_fail++;
         $display("FAIL accept_timeout: dut %0d never raised in_ready, expected 1", id);
      end
      #1;
      in_valid[id] = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 2000 && !ok; t++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && busy == '0 && pend_rdy == '0) ok = 1'b1;
      end
      if (!ok) begin
         n_vec++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      end
   endtask

   // out_ready: directed level or per-cycle random, updated just after each edge.
   initial begin
      out_ready = '1;
      forever begin
         @(posedge clk);
         #2;
         for (int i = 0; i < N; i++)
            out_ready[i] = rand_or[i] ? 1'($urandom_range(0, 1)) : dir_or[i];
      end
   end

   // Monitor: pops an expectation on the first valid cycle, checks it while held.
   always @(negedge clk) begin
      if (!reset) begin
         busy     = '0;
         pend_rdy = '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (pend_rdy[i]) begin
               check("in_ready_after_done", in_ready[i], 1);
               check("out_valid_dropped", out_valid[i], 0);
               pend_rdy[i] = 1'b0;
            end
            if (out_valid[i]) begin
               if (!busy[i]) begin
                  if (exp_q.size() == 0) begin
                     n_vec++;
                     n_fail++;
                     $display("FAIL unexpected_result: dut %0d out_valid=1, expected none", i);
                     cur[i] = '1;
                  end else begin
                     cur[i] = exp_q.pop_front();
                     check("result_dut", i, 32'(cur[i][40:39]));
                     check("out_valid_cycle", cyc, cur[i][31:0]);
                  end
                  busy[i] = 1'b1;
               end
               check("gt_lt_eq", {gt[i], lt[i], eq[i]}, 32'(cur[i][38:36]));
               check("steps", steps_of(i), 32'(cur[i][35:32]));
               check("in_ready_in_done", in_ready[i], 0);
               if (out_ready[i]) begin
                  busy[i]     = 1'b0;
                  pend_rdy[i] = 1'b1;
               end
            end else begin
               check("flags_zero_when_idle", {gt[i], lt[i], eq[i]}, 0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      n_fail++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] m;
      logic [7:0] ra, rb;
      for (int i = 0; i < N; i++) begin
         a_in[i] = '0;
         b_in[i] = '0;
      end
      reset = 1'b0;
      #12;
      for (int i = 0; i < N; i++) check_cleared(i);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("in_ready_before_first_edge", in_ready[0], 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) check("in_ready_after_release", in_ready[i], 1);

      send(0, 8'h5A, 8'h5A, 3'b001, 4'd8, 0, 1'b1);
      send(0, 8'h80, 8'h7F, 3'b100, 4'd1, 0, 1'b1);
      send(0, 8'h01, 8'h00, 3'b100, 4'd8, 0, 1'b1);
      send(0, 8'h3C, 8'h3D, 3'b010, 4'd8, 1, 1'b1);
      drain();
      send(1, 8'h10, 8'h20, 3'b010, 4'd8, 0, 1'b1);
      send(1, 8'h80, 8'h7F, 3'b100, 4'd8, 0, 1'b1);
      send(1, 8'hC3, 8'hC3, 3'b001, 4'd8, 0, 1'b1);
      drain();
      send(2, 8'h10, 8'h0F, 3'b100, 4'd1, 0, 1'b1);
      send(2, 8'h03, 8'h07, 3'b010, 4'd3, 0, 1'b1);
      send(2, 8'h15, 8'h15, 3'b001, 4'd5, 0, 1'b1);
      drain();

      // Backpressure: result held through five stalled DONE cycles.
      dir_or[0] = 1'b0;
      send(0, 8'h03, 8'h07, 3'b010, 4'd6, 0, 1'b1);
      for (int t = 0; t < 50 && !out_valid[0]; t++) @(posedge clk);
      repeat (5) @(posedge clk);
      #1;
      dir_or[0] = 1'b1;
      drain();

      // Abort mid-scan: equal operands need 8 steps, reset lands after 3.
      send(0, 8'h00, 8'h00, 3'b001, 4'd8, 0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_cleared(0);
      #1;
      reset = 1'b1;
      send(0, 8'hFF, 8'hFE, 3'b100, 4'd8, 0, 1'b1);
      drain();

      rand_or = '1;
      for (int id = 0; id < N; id++) begin
         for (int n = 0; n < 150; n++) begin
            ra = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
               0:       rb = ra;
               1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
               default: rb = 8'($urandom_range(0, 255));
            endcase
            m = model(id, ra, rb);
            send(id, ra, rb, m[6:4], m[3:0], $urandom_range(0, 3), 1'b1);
         end
         drain();
      end
      rand_or = '0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
